// File: rtl/perf_event_monitor.sv
// Writeback-stage performance monitor: classifies retiring instructions into
// saturating totals, per-window accumulators and window snapshots, with a registered read port.
module perf_event_monitor #(
   parameter int unsigned NUM_RET = 1,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned WINDOW  = 1000
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [NUM_RET-1:0]     valid_w_i,
   input  logic                   stall_w_i,
   input  logic [32*NUM_RET-1:0]  instr_w_i,
   input  logic                   freeze_i,
   input  logic                   clear_i,
   input  logic [2:0]             rd_sel_i,
   input  logic                   rd_win_i,
   output logic [CNT_W-1:0]       rd_data_o,
   output logic                   snap_valid_o,
   output logic [7:0]             sat_o
);

   localparam bit          WIN_EN = (WINDOW != 0);
   localparam int unsigned POS_W  = (WINDOW == 0) ? 1 : $clog2(WINDOW + 1);
   localparam int unsigned LAST_I = (WINDOW == 0) ? 0 : WINDOW - 1;
   localparam logic [POS_W-1:0] LAST = POS_W'(LAST_I);
   localparam logic [CNT_W-1:0] MAX  = '1;
   localparam logic [CNT_W:0]   ONE  = {{CNT_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDX_CYCLES  = 3'd0,
      IDX_RETIRED = 3'd1,
      IDX_ALU     = 3'd2,
      IDX_LOAD    = 3'd3,
      IDX_STORE   = 3'd4,
      IDX_BRANCH  = 3'd5,
      IDX_OTHER   = 3'd6,
      IDX_STALL   = 3'd7
   } cnt_idx_e;

   logic [CNT_W-1:0] total     [8];
   logic [CNT_W-1:0] accum     [8];
   logic [CNT_W-1:0] snap      [8];
   logic [CNT_W-1:0] total_nxt [8];
   logic [CNT_W-1:0] accum_nxt [8];
   logic [CNT_W:0]   inc       [8];
   logic [7:0]       sat_hit;
   logic [POS_W-1:0] pos;
   logic [6:0]       op;
   logic [CNT_W:0]   sum_t;
   logic [CNT_W:0]   sum_a;

   // Increments are held at CNT_W+1 bits so the saturation compare never wraps
   always_comb begin
      op    = '0;
      sum_t = '0;
      sum_a = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         inc[i] = '0;
      end
      inc[IDX_CYCLES] = ONE;
      inc[IDX_STALL]  = {{CNT_W{1'b0}}, stall_w_i};
      for (int unsigned k = 0; k < NUM_RET; k++) begin
         op = instr_w_i[32*k +: 7];
         if (valid_w_i[k] && !stall_w_i && instr_w_i[32*k +: 32] != 32'h0000_0013) begin
            inc[IDX_RETIRED] = inc[IDX_RETIRED] + ONE;
            case (op)
               7'b0110011, 7'b0010011,
               7'b0010111, 7'b0110111: inc[IDX_ALU]    = inc[IDX_ALU] + ONE;
               7'b0000011:             inc[IDX_LOAD]   = inc[IDX_LOAD] + ONE;
               7'b0100011:             inc[IDX_STORE]  = inc[IDX_STORE] + ONE;
               7'b1100011, 7'b1101111,
               7'b1100111:             inc[IDX_BRANCH] = inc[IDX_BRANCH] + ONE;
               default:                inc[IDX_OTHER]  = inc[IDX_OTHER] + ONE;
            endcase
         end
      end
      for (int unsigned i = 0; i < 8; i++) begin
         sum_t        = {1'b0, total[i]} + inc[i];
         sat_hit[i]   = (sum_t >= {1'b0, MAX});
         total_nxt[i] = sat_hit[i] ? MAX : sum_t[CNT_W-1:0];
         sum_a        = {1'b0, accum[i]} + inc[i];
         accum_nxt[i] = (sum_a >= {1'b0, MAX}) ? MAX : sum_a[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < 8; i++) begin
            total[i] <= '0;
            accum[i] <= '0;
            snap[i]  <= '0;
         end
         pos          <= '0;
         sat_o        <= '0;
         rd_data_o    <= '0;
         snap_valid_o <= 1'b0;
      end else begin
         rd_data_o    <= rd_win_i ? snap[rd_sel_i] : total[rd_sel_i];
         snap_valid_o <= 1'b0;
         if (clear_i) begin
            // Snapshots survive a clear so the last completed window stays readable
            for (int unsigned i = 0; i < 8; i++) begin
               total[i] <= '0;
               accum[i] <= '0;
            end
            pos   <= '0;
            sat_o <= '0;
         end else if (!freeze_i) begin
            for (int unsigned i = 0; i < 8; i++) begin
               total[i] <= total_nxt[i];
            end
            sat_o <= sat_o | sat_hit;
            if (WIN_EN) begin
               if (pos == LAST) begin
                  for (int unsigned i = 0; i < 8; i++) begin
                     snap[i]  <= accum_nxt[i];
                     accum[i] <= '0;
                  end
                  pos          <= '0;
                  snap_valid_o <= 1'b1;
               end else begin
                  for (int unsigned i = 0; i < 8; i++) begin
                     accum[i] <= accum_nxt[i];
                  end
                  pos <= pos + POS_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: three instances cover single/dual lane,
// window snapshots, freeze/clear interaction, WINDOW=0 and narrow-counter saturation.
module tb_perf_event_monitor;

   localparam logic [31:0] I_ADD   = 32'h003100B3;
   localparam logic [31:0] I_ADDI  = 32'h00100093;
   localparam logic [31:0] I_LW    = 32'h0000A083;
   localparam logic [31:0] I_SW    = 32'h0010A023;
   localparam logic [31:0] I_BEQ   = 32'h00000063;
   localparam logic [31:0] I_JAL   = 32'h0000006F;
   localparam logic [31:0] I_NOP   = 32'h00000013;
   localparam logic [31:0] I_FENCE = 32'h0000000F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // u1: one lane, 32-bit counters, 8-cycle window
   logic        rst1, frz1, clr1, win1, stall1, sv1;
   logic [0:0]  val1;
   logic [31:0] ins1, rd1;
   logic [2:0]  sel1;
   logic [7:0]  sat1;

   // u2: two lanes, snapshots disabled
   logic        rst2, frz2, clr2, win2, stall2, sv2;
   logic [1:0]  val2;
   logic [63:0] ins2;
   logic [31:0] rd2;
   logic [2:0]  sel2;
   logic [7:0]  sat2;

   // u3: one lane, 4-bit counters
   logic        rst3, frz3, clr3, win3, stall3, sv3;
   logic [0:0]  val3;
   logic [31:0] ins3;
   logic [3:0]  rd3;
   logic [2:0]  sel3;
   logic [7:0]  sat3;

   perf_event_monitor #(.NUM_RET(1), .CNT_W(32), .WINDOW(8)) u1 (
      .clk_i(clk), .reset_i(rst1), .valid_w_i(val1), .stall_w_i(stall1), .instr_w_i(ins1),
      .freeze_i(frz1), .clear_i(clr1), .rd_sel_i(sel1), .rd_win_i(win1),
      .rd_data_o(rd1), .snap_valid_o(sv1), .sat_o(sat1));

   perf_event_monitor #(.NUM_RET(2), .CNT_W(32), .WINDOW(0)) u2 (
      .clk_i(clk), .reset_i(rst2), .valid_w_i(val2), .stall_w_i(stall2), .instr_w_i(ins2),
      .freeze_i(frz2), .clear_i(clr2), .rd_sel_i(sel2), .rd_win_i(win2),
      .rd_data_o(rd2), .snap_valid_o(sv2), .sat_o(sat2));

   perf_event_monitor #(.NUM_RET(1), .CNT_W(4), .WINDOW(1000)) u3 (
      .clk_i(clk), .reset_i(rst3), .valid_w_i(val3), .stall_w_i(stall3), .instr_w_i(ins3),
      .freeze_i(frz3), .clear_i(clr3), .rd_sel_i(sel3), .rd_win_i(win3),
      .rd_data_o(rd3), .snap_valid_o(sv3), .sat_o(sat3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reads assume the instance is frozen so one tick of latency does not move the value
   task automatic rdchk1(input string tag, input logic win, input logic [2:0] sel, input logic [63:0] exp);
      win1 = win; sel1 = sel; tick(); chk(tag, 64'(rd1), exp);
   endtask

   task automatic rdchk2(input string tag, input logic win, input logic [2:0] sel, input logic [63:0] exp);
      win2 = win; sel2 = sel; tick(); chk(tag, 64'(rd2), exp);
   endtask

   task automatic rdchk3(input string tag, input logic win, input logic [2:0] sel, input logic [63:0] exp);
      win3 = win; sel3 = sel; tick(); chk(tag, 64'(rd3), exp);
   endtask

   logic [31:0] prog [7];

   initial begin
      prog = '{I_ADD, I_LW, I_SW, I_BEQ, I_JAL, I_NOP, I_FENCE};
      rst1 = 1; frz1 = 0; clr1 = 0; win1 = 0; stall1 = 0; val1 = '0; ins1 = I_NOP; sel1 = '0;
      rst2 = 1; frz2 = 0; clr2 = 0; win2 = 0; stall2 = 0; val2 = '0; ins2 = {I_NOP, I_NOP}; sel2 = '0;
      rst3 = 1; frz3 = 0; clr3 = 0; win3 = 0; stall3 = 0; val3 = '0; ins3 = I_NOP; sel3 = '0;

      // Reset state and single-lane classification
      repeat (3) tick();
      chk("rst_rd", 64'(rd1), 0);
      chk("rst_snapv", 64'(sv1), 0);
      chk("rst_sat", 64'(sat1), 0);
      rst1 = 0; val1 = 1;
      for (int i = 0; i < 7; i++) begin
         ins1 = prog[i];
         tick();
      end
      val1 = 0; frz1 = 1;
      rdchk1("t1_cycles",  0, 3'd0, 7);
      rdchk1("t1_retired", 0, 3'd1, 6);
      rdchk1("t1_alu",     0, 3'd2, 1);
      rdchk1("t1_load",    0, 3'd3, 1);
      rdchk1("t1_store",   0, 3'd4, 1);
      rdchk1("t1_branch",  0, 3'd5, 2);
      rdchk1("t1_other",   0, 3'd6, 1);
      rdchk1("t1_stall",   0, 3'd7, 0);
      chk("t1_sat", 64'(sat1), 0);

      // Window pulses every 8 counting cycles
      rst1 = 1; frz1 = 0; tick();
      rst1 = 0; val1 = 1; ins1 = I_ADD;
      for (int n = 1; n <= 20; n++) begin
         tick();
         chk("t3_pulse", 64'(sv1), (n % 8 == 0) ? 1 : 0);
      end
      frz1 = 1; val1 = 0;
      rdchk1("t3_snap_alu",     1, 3'd2, 8);
      rdchk1("t3_snap_cycles",  1, 3'd0, 8);
      rdchk1("t3_snap_retired", 1, 3'd1, 8);
      rdchk1("t3_tot_alu",      0, 3'd2, 20);

      // Freeze mid-window delays the pulse by the frozen cycle count
      rst1 = 1; frz1 = 0; tick();
      rst1 = 0; val1 = 1; ins1 = I_ADD; sel1 = 3'd0; win1 = 0;
      repeat (3) tick();
      frz1 = 1;
      for (int n = 4; n <= 8; n++) begin
         tick();
         chk("t5_frozen_cycles", 64'(rd1), 3);
         chk("t5_frozen_pulse", 64'(sv1), 0);
      end
      frz1 = 0;
      for (int n = 9; n <= 16; n++) begin
         tick();
         chk("t5_pulse", 64'(sv1), (n == 13) ? 1 : 0);
      end
      chk("t5_cycles", 64'(rd1), 10);

      // Clear on the boundary cycle suppresses the snapshot and the pulse
      for (int n = 17; n <= 20; n++) begin
         tick();
         chk("t6_pre_pulse", 64'(sv1), 0);
      end
      clr1 = 1; tick();
      chk("t6_clr_pulse", 64'(sv1), 0);
      clr1 = 0; frz1 = 1; val1 = 0; tick();
      chk("t6_post_pulse", 64'(sv1), 0);
      rdchk1("t6_snap_alu",    1, 3'd2, 8);
      rdchk1("t6_snap_cycles", 1, 3'd0, 8);
      rdchk1("t6_tot_alu",     0, 3'd2, 0);
      rdchk1("t6_tot_cycles",  0, 3'd0, 0);
      frz1 = 0; val1 = 1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         chk("t6_restart_pulse", 64'(sv1), (n == 8) ? 1 : 0);
      end

      // Dual lane with stalls, WINDOW=0
      rst2 = 1; tick();
      rst2 = 0; val2 = 2'b11; ins2 = {I_ADDI, I_ADDI};
      for (int n = 1; n <= 10; n++) begin
         stall2 = (n % 3 == 0);
         tick();
         chk("t2_pulse", 64'(sv2), 0);
      end
      stall2 = 0; ins2 = {I_LW, I_NOP}; tick();
      val2 = '0; frz2 = 1;
      rdchk2("t2_cycles",   0, 3'd0, 11);
      rdchk2("t2_retired",  0, 3'd1, 15);
      rdchk2("t2_alu",      0, 3'd2, 14);
      rdchk2("t2_load",     0, 3'd3, 1);
      rdchk2("t2_other",    0, 3'd6, 0);
      rdchk2("t2_stall",    0, 3'd7, 3);
      rdchk2("t2_snap_alu", 1, 3'd2, 0);
      rdchk2("t2_snap_cyc", 1, 3'd0, 0);

      // 4-bit saturation and clear
      rst3 = 1; tick();
      rst3 = 0; val3 = 1; ins3 = I_ADD;
      repeat (14) tick();
      chk("t4_sat_pre", 64'(sat3), 0);
      tick();
      chk("t4_sat_hit", 64'(sat3), 8'h07);
      repeat (5) tick();
      val3 = 0; frz3 = 1;
      rdchk3("t4_alu",     0, 3'd2, 15);
      rdchk3("t4_retired", 0, 3'd1, 15);
      rdchk3("t4_cycles",  0, 3'd0, 15);
      rdchk3("t4_load",    0, 3'd3, 0);
      chk("t4_sat_hold", 64'(sat3), 8'h07);
      clr3 = 1; tick();
      clr3 = 0;
      chk("t4_sat_clr", 64'(sat3), 0);
      rdchk3("t4_alu_clr", 0, 3'd2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
